// File: rtl/pcileech_tlps128_sink_arb_rr_pkg.sv
// Shared types and helpers for the TLP TX sink arbiter.
// Holds the FSM state type, the TLP stream field widths and the
// priority/round-robin pick function used by pcileech_rr_pick.
package pcileech_tlps_arb_pkg;

    localparam int TLP_DATA_W    = 128;
    localparam int TLP_KEEP_W    = 4;
    localparam int TLP_USER_W    = 9;

    // The pick function works on a fixed maximum width; callers zero-extend.
    localparam int ARB_MAX_SRC   = 8;
    localparam int ARB_IDX_MAX_W = 3;

    typedef enum logic [0:0] {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef struct packed {
        logic                     found;
        logic [ARB_IDX_MAX_W-1:0] idx;
    } rr_pick_t;

    // Lowest-index requester in prio_mask wins outright. Otherwise the first
    // non-prio requester after ptr wins, wrapping explicitly modulo nsrc.
    function automatic rr_pick_t rr_next(
        input logic [ARB_MAX_SRC-1:0]   req,
        input logic [ARB_MAX_SRC-1:0]   prio_mask,
        input logic [ARB_IDX_MAX_W-1:0] ptr,
        input int                       nsrc
    );
        rr_pick_t                 r;
        int                       j;
        logic [ARB_IDX_MAX_W-1:0] sel;
        r = '0;
        // Descending scan so the lowest index is the last one written.
        for (int i = ARB_MAX_SRC - 1; i >= 0; i--) begin
            sel = ARB_IDX_MAX_W'(i);
            if (i < nsrc && req[sel] && prio_mask[sel]) begin
                r.found = 1'b1;
                r.idx   = sel;
            end
        end
        if (!r.found) begin
            // Descending distance so the nearest slot after ptr wins.
            for (int k = ARB_MAX_SRC; k >= 1; k--) begin
                j = int'(ptr) + k;
                if (j >= nsrc) j = j - nsrc;
                sel = ARB_IDX_MAX_W'(j);
                if (k <= nsrc && j < nsrc && req[sel] && !prio_mask[sel]) begin
                    r.found = 1'b1;
                    r.idx   = sel;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pcileech_tlps128_sink_arb_rr_pick.sv
// Combinational strict-priority + rotating-priority encoder.
// Returns the index of the source that should own the TX stream next.
module pcileech_rr_pick
    import pcileech_tlps_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] prio_mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    rr_pick_t w_res;

    assign w_res = rr_next(ARB_MAX_SRC'(req), ARB_MAX_SRC'(prio_mask),
                           ARB_IDX_MAX_W'(ptr), NUM_SRC);
    assign idx   = IDX_W'(w_res.idx);
    assign found = w_res.found;

endmodule

// File: rtl/pcileech_tlps128_sink_arb_rr.sv
// Packet-granular TLP AXI-stream arbiter on the PCIe TX path.
// Strict priority for PRIO_MASK sources, round-robin among the rest; a grant
// is held from the first beat through tlast and re-picked with no bubble.
// Optional stall watchdog: define PCILEECH_TLPS_ARB_WDOG_EN.
module pcileech_tlps128_sink_arb_rr
    import pcileech_tlps_arb_pkg::*;
#(
    parameter int                 NUM_SRC     = 4,
    parameter logic [NUM_SRC-1:0] PRIO_MASK   = NUM_SRC'(1),
    parameter int                 WDOG_CYCLES = 1024
) (
    input  logic                          clk_pcie,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            in_has_data,
    input  logic [NUM_SRC-1:0]            in_tvalid,
    input  logic [NUM_SRC-1:0]            in_tlast,
    input  logic [NUM_SRC*TLP_DATA_W-1:0] in_tdata,
    input  logic [NUM_SRC*TLP_KEEP_W-1:0] in_tkeepdw,
    input  logic [NUM_SRC*TLP_USER_W-1:0] in_tuser,
    output logic [NUM_SRC-1:0]            in_tready,
    output logic                          out_tvalid,
    output logic                          out_tlast,
    output logic [TLP_DATA_W-1:0]         out_tdata,
    output logic [TLP_KEEP_W-1:0]         out_tkeepdw,
    output logic [TLP_USER_W-1:0]         out_tuser,
    output logic                          out_has_data,
    input  logic                          out_tready,
    output logic [$clog2(NUM_SRC)-1:0]    grant_id,
    output logic                          busy,
    output logic                          wdog_err
);

    localparam int IDX_W = $clog2(NUM_SRC);

    if (NUM_SRC < 2 || NUM_SRC > ARB_MAX_SRC || WDOG_CYCLES < 2) begin : g_bad_param
        $error("pcileech_tlps128_sink_arb_rr: unsupported NUM_SRC/WDOG_CYCLES");
    end

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_grant_id;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_ptr_next;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_found;
    logic             w_busy;
    logic             w_xfer;
    logic             w_pkt_end;
    logic             w_release;
    logic             w_wdog_fire;

    logic [TLP_DATA_W-1:0] w_data [NUM_SRC];
    logic [TLP_KEEP_W-1:0] w_keep [NUM_SRC];
    logic [TLP_USER_W-1:0] w_user [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign w_data[g] = in_tdata[g*TLP_DATA_W +: TLP_DATA_W];
        assign w_keep[g] = in_tkeepdw[g*TLP_KEEP_W +: TLP_KEEP_W];
        assign w_user[g] = in_tuser[g*TLP_USER_W +: TLP_USER_W];
    end

    assign w_busy       = (r_state == ARB_BUSY);
    assign busy         = w_busy;
    assign grant_id     = r_grant_id;
    assign out_has_data = |in_has_data;

    // Route the granted source to the core; everything is zero while idle.
    always_comb begin
        out_tvalid  = 1'b0;
        out_tlast   = 1'b0;
        out_tdata   = '0;
        out_tkeepdw = '0;
        out_tuser   = '0;
        in_tready   = '0;
        if (w_busy) begin
            out_tvalid            = in_tvalid[r_grant_id];
            out_tlast             = in_tlast[r_grant_id];
            out_tdata             = w_data[r_grant_id];
            out_tkeepdw           = w_keep[r_grant_id];
            out_tuser             = w_user[r_grant_id];
            in_tready[r_grant_id] = out_tready;
        end
    end

    assign w_xfer    = out_tvalid && out_tready;
    assign w_pkt_end = w_xfer && out_tlast;
    assign w_release = w_pkt_end || w_wdog_fire;

    // Pointer advances past a finished non-prio owner before the same-cycle
    // re-pick, so the next RR candidate is the one after it.
    assign w_ptr_next = (w_release && !PRIO_MASK[r_grant_id]) ? r_grant_id : r_rr_ptr;

    pcileech_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (in_has_data),
        .prio_mask (PRIO_MASK),
        .ptr       (w_ptr_next),
        .idx       (w_pick_idx),
        .found     (w_pick_found)
    );

`ifdef PCILEECH_TLPS_ARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES);

    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_wdog_err;

    // Fires on the WDOG_CYCLES-th consecutive cycle the owner has no beat.
    assign w_wdog_fire = w_busy && !in_tvalid[r_grant_id] &&
                         (r_stall_cnt == CNT_W'(WDOG_CYCLES - 1));
    assign wdog_err    = r_wdog_err;

    // Count owner stalls; sink backpressure holds the count, beats clear it.
    always_ff @(posedge clk_pcie) begin
        if (rst || !w_busy || w_xfer || w_wdog_fire)
            r_stall_cnt <= '0;
        else if (!in_tvalid[r_grant_id])
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    // One-cycle error pulse on forced release.
    always_ff @(posedge clk_pcie) begin
        if (rst) r_wdog_err <= 1'b0;
        else     r_wdog_err <= w_wdog_fire;
    end
`else
    assign w_wdog_fire = 1'b0;
    assign wdog_err    = 1'b0;
`endif

    // Grant FSM: one bubble out of IDLE, back-to-back re-grant on tlast.
    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= IDX_W'(NUM_SRC - 1);
        end else begin
            r_rr_ptr <= w_ptr_next;
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_found) begin
                        r_grant_id <= w_pick_idx;
                        r_state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (w_wdog_fire) begin
                        r_state <= ARB_IDLE;
                    end else if (w_pkt_end) begin
                        if (w_pick_found) r_grant_id <= w_pick_idx;
                        else              r_state    <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcileech_tlps128_sink_arb_rr.sv
// Directed bench for pcileech_tlps128_sink_arb_rr (4 sources, src0 prio).
// Each source is a tiny packet counter; has_data excludes the packet that
// currently owns the grant. Expected grants are hand-derived constants.
module tb_pcileech_tlps128_sink_arb_rr;

    logic         clk_pcie = 1'b0;
    logic         rst;
    logic [3:0]   in_has_data, in_tvalid, in_tlast, in_tready;
    logic [511:0] in_tdata;
    logic [15:0]  in_tkeepdw;
    logic [35:0]  in_tuser;
    logic         out_tvalid, out_tlast, out_has_data, out_tready;
    logic [127:0] out_tdata;
    logic [3:0]   out_tkeepdw;
    logic [8:0]   out_tuser;
    logic [1:0]   grant_id;
    logic         busy, wdog_err;

    int         npkt [4];
    int         beat [4];
    int         plen [4];
    logic [3:0] stall;
    int         q_pkt [$];
    int         n_chk = 0;
    int         n_pass = 0;

    pcileech_tlps128_sink_arb_rr #(
        .NUM_SRC(4), .PRIO_MASK(4'b0001), .WDOG_CYCLES(16)
    ) dut (
        .clk_pcie(clk_pcie), .rst(rst),
        .in_has_data(in_has_data), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
        .in_tdata(in_tdata), .in_tkeepdw(in_tkeepdw), .in_tuser(in_tuser),
        .in_tready(in_tready),
        .out_tvalid(out_tvalid), .out_tlast(out_tlast), .out_tdata(out_tdata),
        .out_tkeepdw(out_tkeepdw), .out_tuser(out_tuser),
        .out_has_data(out_has_data), .out_tready(out_tready),
        .grant_id(grant_id), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk_pcie = ~clk_pcie;

    // Source models: beat/packet counters drive the per-source stream.
    always_comb begin
        in_has_data = '0;
        in_tvalid   = '0;
        in_tlast    = '0;
        in_tdata    = '0;
        in_tkeepdw  = '1;
        in_tuser    = '0;
        for (int i = 0; i < 4; i++) begin
            in_has_data[i] = npkt[i] > ((busy && grant_id == 2'(i)) ? 1 : 0);
            in_tvalid[i]   = (npkt[i] > 0) && !stall[i];
            in_tlast[i]    = (beat[i] == plen[i] - 1);
            in_tdata[128*i +: 128] = {32'hC0DE_0000 + 32'(i), 32'(beat[i]), 64'h0};
            in_tuser[9*i +: 9]     = {8'h0, beat[i] == 0};
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample handshakes, step the edge, advance the source models.
    task automatic tick();
        logic [3:0] acc;
        #1;
        acc = in_tvalid & in_tready;
        if (out_tvalid && out_tready && out_tlast) q_pkt.push_back(int'(grant_id));
        @(posedge clk_pcie);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                if (beat[i] == plen[i] - 1) begin beat[i] = 0; npkt[i]--; end
                else beat[i]++;
            end
        end
        #1;
    endtask

    task automatic clr_src();
        for (int i = 0; i < 4; i++) begin npkt[i] = 0; beat[i] = 0; plen[i] = 1; end
        stall = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_tready = 1'b1; clr_src();
        tick(); tick();
        rst = 1'b0;
        q_pkt.delete();
    endtask

    function automatic int qget(input int k);
        return (q_pkt.size() > k) ? q_pkt[k] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr_src();
        rst = 1'b1; out_tready = 1'b1;

        // 1: reset state, bubble out of IDLE, zero-bubble re-grant
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_tvalid", out_tvalid, 0);
        chk("rst_tready", in_tready, 0);
        chk("rst_wdog", wdog_err, 0);
        npkt[1] = 1; npkt[2] = 1;
        #1;
        chk("t1_has_data", out_has_data, 1);
        chk("t1_bubble", busy, 0);
        tick();
        chk("t1_g1_busy", busy, 1);
        chk("t1_g1_id", grant_id, 1);
        chk("t1_g1_tready", in_tready, 4'b0010);
        chk("t1_g1_data", out_tdata[127:96], 32'hC0DE_0001);
        chk("t1_g1_user", out_tuser, 9'h001);
        tick();
        chk("t1_g2_busy", busy, 1);
        chk("t1_g2_id", grant_id, 2);
        chk("t1_g2_tready", in_tready, 4'b0100);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_tvalid", out_tvalid, 0);

        // 2: prio source drains first, then RR order 1,2,3
        do_reset();
        npkt[0] = 3; npkt[1] = 1; npkt[2] = 1; npkt[3] = 1;
        for (int c = 0; c < 20 && q_pkt.size() < 6; c++) tick();
        chk("t2_npkts", q_pkt.size(), 6);
        chk("t2_p0", qget(0), 0);
        chk("t2_p1", qget(1), 0);
        chk("t2_p2", qget(2), 0);
        chk("t2_p3", qget(3), 1);
        chk("t2_p4", qget(4), 2);
        chk("t2_p5", qget(5), 3);
        chk("t2_idle", busy, 0);

        // 3: prio request mid-packet does not preempt
        do_reset();
        plen[2] = 3; npkt[2] = 1;
        tick();
        chk("t3_g2", grant_id, 2);
        tick();
        npkt[0] = 1;
        chk("t3_beat1_user", out_tuser, 9'h000);
        tick();
        chk("t3_hold_id", grant_id, 2);
        chk("t3_hold_tready", in_tready, 4'b0100);
        chk("t3_hold_data", out_tdata[95:64], 32'd2);
        tick();
        chk("t3_g0", grant_id, 0);
        chk("t3_g0_busy", busy, 1);
        tick();
        chk("t3_order", {qget(0), qget(1)}, {32'd2, 32'd0});

        // 4: tlast under backpressure holds the grant
        do_reset();
        plen[1] = 2; npkt[1] = 1; npkt[3] = 1;
        tick();
        chk("t4_g1", grant_id, 1);
        tick();
        out_tready = 1'b0;
        tick(); tick(); tick();
        chk("t4_hold_busy", busy, 1);
        chk("t4_hold_id", grant_id, 1);
        chk("t4_hold_last", out_tlast, 1);
        chk("t4_hold_tready", in_tready, 4'b0000);
        out_tready = 1'b1;
        #1;
        chk("t4_rel_tready", in_tready, 4'b0010);
        tick();
        chk("t4_g3", grant_id, 3);
        chk("t4_g3_busy", busy, 1);

        // 5: owner stalls mid-packet
        do_reset();
        plen[3] = 4; npkt[3] = 1;
        tick();
        chk("t5_g3", grant_id, 3);
        tick();
        stall[3] = 1'b1; npkt[1] = 1;
`ifdef PCILEECH_TLPS_ARB_WDOG_EN
        repeat (15) tick();
        chk("t5_pre_wdog", wdog_err, 0);
        chk("t5_pre_busy", busy, 1);
        tick();
        chk("t5_wdog", wdog_err, 1);
        chk("t5_wdog_idle", busy, 0);
        chk("t5_wdog_tready", in_tready, 4'b0000);
        stall = '0; npkt[3] = 0; beat[3] = 0;
        tick();
        chk("t5_wdog_clr", wdog_err, 0);
        chk("t5_next_busy", busy, 1);
        chk("t5_next_id", grant_id, 1);
`else
        repeat (20) tick();
        chk("t5_nowdog_err", wdog_err, 0);
        chk("t5_nowdog_busy", busy, 1);
        chk("t5_nowdog_id", grant_id, 3);
`endif

        // 6: reset mid-packet drops the grant and the RR pointer
        do_reset();
        npkt[1] = 1; plen[2] = 3; npkt[2] = 1;
        tick();
        chk("t6_g1", grant_id, 1);
        tick();
        chk("t6_g2", grant_id, 2);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_busy", busy, 0);
        chk("t6_tvalid", out_tvalid, 0);
        chk("t6_tready", in_tready, 4'b0000);
        chk("t6_grant", grant_id, 0);
        clr_src();
        rst = 1'b0;
        npkt[1] = 1; npkt[2] = 1;
        tick();
        chk("t6_ptr_pick", grant_id, 1);
        chk("t6_ptr_busy", busy, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
